// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and types used by the register file and its decoders.
package cpu_pkg;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]   xword_t;

    localparam reg_idx_t ZERO_REG = 5'd31;

endpackage : cpu_pkg

// File: rtl/regfile_wb_64_decoder.sv
// One-hot 5-to-32 enable decoder, shared with the other write-enable decoders.
module decoder_5_32
    import cpu_pkg::*;
(
    input  logic [4:0]  in,
    input  logic        en,
    output logic [31:0] out
);

    // one-hot select, all zero when disabled
    always_comb begin
        out = 32'd0;
        for (int k = 0; k < 32; k++) begin
            if (en && (in == 5'(k))) begin
                out[k] = 1'b1;
            end else begin
                out[k] = 1'b0;
            end
        end
    end

endmodule : decoder_5_32

// File: rtl/regfile_wb_64.sv
// 32 x 64-bit register file: one synchronous write port, two combinational read ports, X31 reads as zero.
// Optional write-through from the write port to the read ports when REGFILE_BYPASS_EN is defined.
module regfile_wb_64
    import cpu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    logic [31:0]      dec_s;
    logic [31:0]      wen_s;
    logic [WIDTH-1:0] regs_q    [NREGS-1];
    logic [WIDTH-1:0] regs_d    [NREGS-1];
    logic [WIDTH-1:0] rd_view_s [NREGS];
    logic [WIDTH-1:0] rd1_raw_s;
    logic [WIDTH-1:0] rd2_raw_s;

    decoder_5_32 u_wdec (
        .in  (WriteRegister),
        .en  (RegWrite),
        .out (dec_s)
    );

    // X31 has no storage, so its enable is dropped here
    assign wen_s = dec_s & 32'h7FFF_FFFF;

    // next-state of each register bank entry
    always_comb begin
        for (int k = 0; k < NREGS - 1; k++) begin
            if (wen_s[k]) begin
                regs_d[k] = WriteData;
            end else begin
                regs_d[k] = regs_q[k];
            end
        end
    end

    // register bank with synchronous reset taking priority over writes
    always_ff @(posedge clk) begin
        for (int k = 0; k < NREGS - 1; k++) begin
            if (reset) begin
                regs_q[k] <= {WIDTH{1'b0}};
            end else begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    // read view: stored entries plus a hard zero in the X31 slot
    always_comb begin
        for (int k = 0; k < NREGS - 1; k++) begin
            rd_view_s[k] = regs_q[k];
        end
        rd_view_s[NREGS-1] = {WIDTH{1'b0}};
    end

    assign rd1_raw_s = rd_view_s[ReadRegister1];
    assign rd2_raw_s = rd_view_s[ReadRegister2];

`ifdef REGFILE_BYPASS_EN
    // write-through: a same-cycle write to the read index is forwarded, reset forces zero
    always_comb begin
        if (reset) begin
            ReadData1 = {WIDTH{1'b0}};
            ReadData2 = {WIDTH{1'b0}};
        end else begin
            if (RegWrite && (WriteRegister == ReadRegister1) && (WriteRegister != ZERO_REG)) begin
                ReadData1 = WriteData;
            end else begin
                ReadData1 = rd1_raw_s;
            end
            if (RegWrite && (WriteRegister == ReadRegister2) && (WriteRegister != ZERO_REG)) begin
                ReadData2 = WriteData;
            end else begin
                ReadData2 = rd2_raw_s;
            end
        end
    end
`else
    // stored values only; same-cycle hazards are left to the forwarding unit
    always_comb begin
        ReadData1 = rd1_raw_s;
        ReadData2 = rd2_raw_s;
    end
`endif

endmodule : regfile_wb_64

// File: tb/tb_regfile_wb_64.sv
// Directed self-checking bench for regfile_wb_64; expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_wb_64;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int total = 0;
    int bad   = 0;
    logic [63:0] model [32];

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    regfile_wb_64 dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; RegWrite = 1'b0; WriteRegister = 5'd0; WriteData = 64'd0;
        ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
        tick();
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            #1;
            check_val($sformatf("rst_rd1_x%0d", i), ReadData1, 64'd0);
            check_val($sformatf("rst_rd2_x%0d", 31 - i), ReadData2, 64'd0);
        end

        RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 64'hDEADBEEF_CAFEF00D;
        tick();
        model[5] = 64'hDEADBEEF_CAFEF00D;
        RegWrite = 1'b0; ReadRegister1 = 5'd5; ReadRegister2 = 5'd5;
        #1;
        check_val("wr_x5_rd1", ReadData1, 64'hDEADBEEF_CAFEF00D);
        check_val("wr_x5_rd2", ReadData2, 64'hDEADBEEF_CAFEF00D);
        ReadRegister1 = 5'd4; ReadRegister2 = 5'd6;
        #1;
        check_val("x4_zero", ReadData1, 64'd0);
        check_val("x6_zero", ReadData2, 64'd0);

        RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = 64'hFFFF_FFFF_FFFF_FFFF;
        ReadRegister1 = 5'd31;
        #1;
        check_val("x31_same_cycle", ReadData1, 64'd0);
        tick();
        RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(i);
            #1;
            check_val($sformatf("after_x31_rd1_x%0d", i), ReadData1, model[i]);
            check_val($sformatf("after_x31_rd2_x%0d", i), ReadData2, model[i]);
        end

        RegWrite = 1'b0; WriteRegister = 5'd7; WriteData = 64'h1234;
        tick();
        ReadRegister1 = 5'd7;
        #1;
        check_val("disabled_x7", ReadData1, 64'd0);

        RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 64'hAAAA;
        tick();
        WriteData = 64'h5555; ReadRegister1 = 5'd9; ReadRegister2 = 5'd8;
        #1;
        check_val("same_cycle_x9", ReadData1, BYPASS ? 64'h5555 : 64'hAAAA);
        check_val("same_cycle_other", ReadData2, 64'd0);
        tick();
        RegWrite = 1'b0;
        #1;
        check_val("next_cycle_x9", ReadData1, 64'h5555);

        reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 64'h77;
        ReadRegister1 = 5'd3; ReadRegister2 = 5'd5;
        #1;
        check_val("rst_cycle_x3", ReadData1, 64'd0);
        check_val("rst_cycle_x5", ReadData2, BYPASS ? 64'd0 : 64'hDEADBEEF_CAFEF00D);
        tick();
        reset = 1'b0; RegWrite = 1'b0;
        #1;
        check_val("rst_prio_x3", ReadData1, 64'd0);
        check_val("rst_clr_x5", ReadData2, 64'd0);
        ReadRegister1 = 5'd9;
        #1;
        check_val("rst_clr_x9", ReadData1, 64'd0);

        RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 64'h77;
        tick();
        WriteRegister = 5'd0; WriteData = 64'h8000_0000_0000_0001;
        tick();
        RegWrite = 1'b0; ReadRegister1 = 5'd3; ReadRegister2 = 5'd0;
        #1;
        check_val("post_rst_x3", ReadData1, 64'h77);
        check_val("exact_x0", ReadData2, 64'h8000_0000_0000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_wb_64

// File: doc/regfile_wb_64.md
# regfile_wb_64

Write-side counterpart of the 64-bit datapath read-select muxes. A 32-entry × 64-bit register file with:
- one synchronous write port driven through a one-hot 5→32 write decoder;
- two combinational read ports.

It sits between the write-back stage (write port) and the decode stage (read ports) of the pipelined CPU. X31 is the architectural zero register.

## Interface
Parameters:
- `WIDTH`, default 64: data width per register.
- `NREGS`, default 32: register count; the address is `$clog2(NREGS)` = 5 bits.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high; clears every register.
- `RegWrite`  input  1  write enable for the write-back port.
- `WriteRegister`  input  5  destination register index.
- `WriteData`  input  64  data to write.
- `ReadRegister1`  input  5  read port 1 index.
- `ReadRegister2`  input  5  read port 2 index.
- `ReadData1`  output  64  read port 1 data, combinational.
- `ReadData2`  output  64  read port 2 data, combinational.

## Operation
- Storage is `regs[0..30]`, each 64-bit. There is no storage for index 31.
- Write decoder:
  - Output is a one-hot `wen[31:0]`: `wen[WriteRegister] = RegWrite`; all other bits are 0.
  - `wen[31]` is forced to 0.
- On a rising `clk` with `reset`=1: all `regs` become 0; any write in that cycle is discarded. Reset has priority.
- On a rising `clk` with `reset`=0 and `wen[k]`=1: `regs[k] <= WriteData`. All other registers hold.
- Reads:
  - `ReadDataN = (ReadRegisterN == 31) ? 0 : regs[ReadRegisterN]`.
  - Reads are purely combinational from the address and the stored state.
- Both read ports may address the same register, or the write target, in the same cycle. There is no port conflict.
- Writes to X31 are silently dropped. A later read of X31 still returns 0.
- Reset mid-operation: a write asserted in the reset cycle is lost. The first write that takes effect is in the first cycle where `reset`=0.
- There is no width conversion. `WriteData` is stored exactly, with no sign or zero extension.

## Timing
- Write latency: data is visible on the read ports starting the cycle after the capturing edge. This applies in non-bypass mode; see Configuration for bypass mode.
- Read latency: 0 cycles (combinational). The path is address → mux tree → `ReadDataN` within the same cycle.
- Output values in and after reset: `ReadData1` = `ReadData2` = 0 for every address, from the first edge with `reset`=1 until the first effective write.
- Before the first reset, register contents are X. The bench must apply reset before checking.
- Simultaneous read and write of the same register in one cycle: behaviour is defined by `REGFILE_BYPASS_EN` (see Configuration).

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined (write-through):
  - Condition: `RegWrite`=1, `WriteRegister`==`ReadRegisterN`, and `WriteRegister`!=31.
  - Under that condition, `ReadDataN` = `WriteData` in the same cycle, before the edge.
  - This removes the write-back→decode hazard without extra forwarding logic.
  - `reset`=1 suppresses the bypass; output is 0.
- Undefined:
  - `ReadDataN` shows the old stored value until the capturing edge.
  - The pipeline forwarding unit must cover the same-cycle case.

## Structure
- Shared package `cpu_pkg` holds:
  - `XLEN` = 64, `NREGS` = 32, `REG_AW` = 5, `ZERO_REG` = 5'd31;
  - typedef `reg_idx_t` (logic [4:0]);
  - typedef `xword_t` (logic [63:0]).
- Sub-module `decoder_5_32`: inputs `in[4:0]` and `en`; output one-hot `out[31:0]`. It is reused by other write-enable decoders.
- Read ports are built from the existing 64-bit mux primitives arranged as a 32:1 tree, one tree per port.
- Registers are per-entry 64-bit D flip-flop banks with enable and synchronous reset.

## Test plan
- Reset check: assert `reset` for 1 cycle, then read all 32 indices on both ports → 0 everywhere.
- Basic write/read: write X5=64'hDEADBEEF_CAFEF00D, then the next cycle read port 1=5 and port 2=5 → both return that value. X4 and X6 stay 0.
- Zero register: write X31=64'hFFFF_FFFF_FFFF_FFFF, next cycle read X31 → 0. Confirm no other register changed.
- Disabled write: `RegWrite`=0, `WriteRegister`=7, `WriteData`=64'h1234 → X7 stays at its prior value (0 after reset).
- Same-cycle read/write: X9 holds 64'hAAAA. In one cycle write 64'h5555 to X9 and read X9 → `ReadData1` = 64'h5555 with `REGFILE_BYPASS_EN`, 64'hAAAA without it. Both builds return 64'h5555 the next cycle.
- Reset priority: `reset`=1 and `RegWrite`=1 for X3=64'h77 on the same edge → X3 reads 0 afterward.
